// File: rtl/ub_dma_pkg.sv
// Shared types for the UnifiedBuffer DMA burst sequencer.
// Holds the FSM state encoding and the command direction codes.
package ub_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } seq_state_t;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/ub_dma_sequencer_if.sv
// Bundle of the command, write-stream, read-stream and UB DMA port signals.
// Ports: cmd_* (command offer), wr_* (DRAM->UB stream), rd_* (UB->DRAM stream),
//        ub_* (UB DMA port), busy/done (status). slave = sequencer, master = its environment.
interface ub_dma_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              ub_write_en;
  logic              ub_read_en;
  logic [ADDR_W-1:0] ub_addr;
  logic [DATA_W-1:0] ub_wdata;
  logic [DATA_W-1:0] ub_rdata;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, ub_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output ub_write_en, ub_read_en, ub_addr, ub_wdata,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, ub_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  ub_write_en, ub_read_en, ub_addr, ub_wdata,
    input  busy, done
  );

endinterface

// File: rtl/ub_rd_skid.sv
// Two-entry read-return FIFO with push/pop/count and asynchronous reset.
// Ports: i_push/i_data (UB return word), i_pop (consumer take), o_valid/o_data (head), o_count.
module ub_rd_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  // An empty FIFO passes the returning word straight through, so a
  // word arriving and leaving in the same cycle never occupies a slot.
  assign w_empty  = (r_count == 2'd0);
  assign w_bypass = w_empty & i_push & i_pop;
  assign w_wr     = i_push & ~w_bypass;
  assign w_rd     = i_pop & ~w_empty;

  assign o_valid = ~w_empty | i_push;
  assign o_data  = ~w_empty ? r_mem[r_rptr]
                 : (i_push ? i_data : '0);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_wr) r_wptr <= ~r_wptr;
      if (w_rd) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule

// File: rtl/ub_dma_sequencer.sv
// Burst sequencer between the DRAM-side streams and the UnifiedBuffer DMA port.
// Ports: clk, reset (async, active-high), bus (ub_dma_sequencer_if.slave).
module ub_dma_sequencer
  import ub_dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input logic            clk,
  input logic            reset,
  ub_dma_sequencer_if.slave bus
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_inflight;

  logic              w_accept;
  logic              w_wr_fire;
  logic              w_rd_issue;
  logic              w_last;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [DATA_W-1:0] w_fifo_data;
  logic [1:0]        w_count;

  assign w_accept  = bus.cmd_valid & (r_state == IDLE);
  assign w_wr_fire = (r_state == WRITE) & bus.wr_valid;
  // Credit check: FIFO words plus the read still in the UB pipe
  // must leave room for the word this issue will return.
  assign w_rd_issue = (r_state == READ) &
    (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2);
  assign w_last = (r_rem == LEN_W'(1));
  assign w_pop  = w_fifo_valid & bus.rd_ready;

  ub_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (bus.ub_rdata),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      if (w_accept) begin
        r_addr <= bus.cmd_addr;
        r_rem  <= bus.cmd_len;
      end else if (w_wr_fire | w_rd_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.cmd_len == '0)          w_next = DONE;
          else if (bus.cmd_dir == DIR_RD) w_next = READ;
          else                            w_next = WRITE;
        end
      end
      WRITE: if (w_wr_fire & w_last)  w_next = DONE;
      READ:  if (w_rd_issue & w_last) w_next = DRAIN;
      DRAIN: begin
        if (!r_inflight && w_count == 2'd0) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = (r_state == IDLE);
    bus.busy        = (r_state != IDLE);
    bus.done        = (r_state == DONE);
    bus.wr_ready    = (r_state == WRITE);
    bus.ub_write_en = w_wr_fire;
    bus.ub_read_en  = w_rd_issue;
    bus.ub_addr     = '0;
    bus.ub_wdata    = '0;
    bus.rd_valid    = w_fifo_valid;
    bus.rd_data     = w_fifo_data;
    if (w_wr_fire | w_rd_issue) bus.ub_addr = r_addr;
    if (w_wr_fire)              bus.ub_wdata = bus.wr_data;
  end

endmodule
